// File: rtl/crossbar_slave_port.sv
// Crossbar slave-side source: decodes the header destination, buffers beats in a
// small FIFO and offers the head beat to the addressed master's arbiter.
module crossbar_slave_port #(
  parameter int DATA_WIDTH = 32,
  parameter int N_MASTERS  = 2,
  parameter int DEST_W     = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic [DEST_W-1:0]     s_dest_o,
  output logic                  s_valid_o,
  output logic                  s_last_o,
  input  logic [N_MASTERS-1:0]  s_ready_i,
  output logic                  drop_o,
  output logic [7:0]            drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 1 + DEST_W;
  localparam logic [AW:0]       DEPTH_C = DEPTH[AW:0];
  localparam logic [DEST_W:0]   NM_C    = N_MASTERS[DEST_W:0];
  localparam logic [AW-1:0]     PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]       CNT_ONE = (AW + 1)'(1'b1);

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state_r;
  logic [DEST_W-1:0] dest_r;
  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;

  logic [DEST_W-1:0] hdr_dest_s;
  logic              hdr_ok_s;
  logic              full_s;
  logic              xfer_in_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_evt_s;
  logic              ready_sel_s;
  logic [DEST_W-1:0] wr_dest_s;

  assign hdr_dest_s = in_data[DATA_WIDTH-1 -: DEST_W];
  assign hdr_ok_s   = ({1'b0, hdr_dest_s} < NM_C);
  assign full_s     = (count_r == DEPTH_C);
  // No bypass: a full FIFO blocks upstream even when the head is leaving this cycle.
  assign in_ready   = (state_r == ST_DROP) | ~full_s;
  assign xfer_in_s  = in_valid & in_ready;

  // Head beat straight from storage; never a combinational function of s_ready_i.
  assign {s_data_o, s_last_o, s_dest_o} = mem_r[rd_ptr_r];
  assign s_valid_o = (count_r != {(AW + 1){1'b0}});

  // Select the ready bit of the arbiter the head beat is addressed to.
  always_comb begin
    ready_sel_s = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      ready_sel_s = ready_sel_s | (s_ready_i[i] & (s_dest_o == DEST_W'(i)));
    end
  end

  assign pop_s = s_valid_o & ready_sel_s;

  // Decide whether the incoming beat is stored, discarded or closes a dropped packet.
  always_comb begin
    push_s     = 1'b0;
    drop_evt_s = 1'b0;
    wr_dest_s  = dest_r;
    case (state_r)
      ST_HEAD: begin
        if (hdr_ok_s) begin
          push_s    = xfer_in_s;
          wr_dest_s = hdr_dest_s;
        end else begin
          drop_evt_s = xfer_in_s & in_last;
        end
      end
      ST_FWD: begin
        push_s = xfer_in_s;
      end
      ST_DROP: begin
        drop_evt_s = xfer_in_s & in_last;
      end
      default: begin
        push_s     = 1'b0;
        drop_evt_s = 1'b0;
      end
    endcase
  end

  // Input packet FSM with latched destination and drop reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HEAD;
      dest_r     <= {DEST_W{1'b0}};
      drop_o     <= 1'b0;
      drop_cnt_o <= 8'd0;
    end else begin
      drop_o <= drop_evt_s;
      if (drop_evt_s && (drop_cnt_o != 8'hFF)) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
      case (state_r)
        ST_HEAD: begin
          if (xfer_in_s) begin
            if (hdr_ok_s) begin
              dest_r <= hdr_dest_s;
              if (!in_last) state_r <= ST_FWD;
            end else if (!in_last) begin
              state_r <= ST_DROP;
            end
          end
        end
        ST_FWD: begin
          if (xfer_in_s && in_last) state_r <= ST_HEAD;
        end
        ST_DROP: begin
          if (xfer_in_s && in_last) state_r <= ST_HEAD;
        end
        default: begin
          state_r <= ST_HEAD;
        end
      endcase
    end
  end

  // FIFO storage and pointers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_data, in_last, wr_dest_s};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_slave_port.sv
// Randomized bench for crossbar_slave_port against a queue-based packet model.
module tb_crossbar_slave_port;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] s_data_o;
  logic [1:0]  s_dest_o;
  logic        s_valid_o;
  logic        s_last_o;
  logic [1:0]  s_ready_i = 2'b00;
  logic        drop_o;
  logic [7:0]  drop_cnt_o;

  int total = 0;
  int bad = 0;

  // reference model state
  beat_t    q[$];
  bit       in_pkt = 1'b0;
  bit       dropping = 1'b0;
  bit [1:0] cur_dest = 2'd0;
  int       exp_cnt = 0;
  bit       rand_ready = 1'b0;

  crossbar_slave_port dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .s_data_o(s_data_o), .s_dest_o(s_dest_o), .s_valid_o(s_valid_o), .s_last_o(s_last_o),
    .s_ready_i(s_ready_i), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    in_pkt = 1'b0;
    dropping = 1'b0;
    cur_dest = 2'd0;
    exp_cnt = 0;
  endtask

  // One clock: compare outputs with the model, advance model and DUT together.
  task automatic tick(output bit acc);
    bit    exp_rdy;
    bit    pop;
    bit    pulse;
    beat_t nb;
    if (rand_ready) s_ready_i = 2'($urandom);
    exp_rdy = dropping || (q.size() < DEPTH);
    check("in_ready", in_ready, exp_rdy);
    check("s_valid", s_valid_o, q.size() != 0);
    pop = 1'b0;
    if (q.size() != 0) begin
      check("s_data", s_data_o, q[0].data);
      check("s_dest", s_dest_o, q[0].dest);
      check("s_last", s_last_o, q[0].last);
      pop = s_ready_i[q[0].dest];
    end
    acc = in_valid && exp_rdy;
    pulse = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc) begin
      nb.data = in_data;
      nb.last = in_last;
      if (dropping) begin
        if (in_last) begin dropping = 1'b0; pulse = 1'b1; end
      end else if (in_pkt) begin
        nb.dest = cur_dest;
        q.push_back(nb);
        if (in_last) in_pkt = 1'b0;
      end else if (in_data[31:30] < 2) begin
        cur_dest = in_data[31:30];
        nb.dest = cur_dest;
        q.push_back(nb);
        in_pkt = !in_last;
      end else if (in_last) begin
        pulse = 1'b1;
      end else begin
        dropping = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (pulse && exp_cnt < 255) exp_cnt++;
    check("drop_o", drop_o, pulse);
    check("drop_cnt", drop_cnt_o, exp_cnt);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int len);
    bit acc;
    int n;
    for (int b = 0; b < len; b++) begin
      in_data  = (b == 0) ? hdr : $urandom;
      in_last  = (b == len - 1);
      in_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 500) begin
        tick(acc);
        n++;
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      idle(1);
      n++;
    end
    check("drain", q.size(), 0);
    idle(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit acc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", s_valid_o, 1'b0);
    check("rst_data", s_data_o, 32'd0);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_ready", in_ready, 1'b1);

    // single beat to master 0
    s_ready_i = 2'b01;
    send_pkt(32'h0000_00AA, 1);
    check("first_valid", s_valid_o, 1'b1);
    check("first_data", s_data_o, 32'h0000_00AA);
    idle(1);
    check("first_popped", s_valid_o, 1'b0);

    // dest 1 packet held by the wrong ready bit, then released
    send_pkt(32'h4000_0011, 3);
    idle(4);
    check("held_dest", s_dest_o, 2'd1);
    s_ready_i = 2'b10;
    drain();

    // fill, block and wrap
    s_ready_i = 2'b00;
    for (int i = 0; i < 4; i++) send_pkt(32'h0000_0100 + i, 1);
    idle(1);
    check("full_ready", in_ready, 1'b0);
    s_ready_i = 2'b01;
    for (int i = 4; i < 6; i++) send_pkt(32'h0000_0100 + i, 1);
    drain();

    // out-of-range packet then a good one
    send_pkt(32'hC000_0000, 3);
    check("one_drop", drop_cnt_o, 8'd1);
    send_pkt(32'h0000_0077, 2);
    drain();

    // reset in the middle of a packet
    s_ready_i = 2'b00;
    in_data = 32'h4000_0000; in_last = 1'b0; in_valid = 1'b1;
    tick(acc);
    in_data = 32'h1234_5678;
    tick(acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", s_valid_o, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_ready_i = 2'b01;
    send_pkt(32'h0000_0055, 1);
    check("after_rst_dest", s_dest_o, 2'd0);
    drain();

    // randomized traffic
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom, $urandom_range(1, 4));
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    s_ready_i = 2'b11;
    drain();

    // saturation of the drop counter
    for (int i = 0; i < 300; i++) begin
      send_pkt((i % 2 == 0) ? 32'h8000_0000 : 32'hC000_0000, 1);
    end
    idle(1);
    check("drop_sat", drop_cnt_o, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
